// File: rtl/control_multicycle_pkg.sv
// Shared definitions for the RV64I multicycle core: opcodes, FSM state
// encodings and the datapath select encodings driven by the control FSM.
package control_multicycle_pkg;

  localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPCODE_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
  localparam logic [6:0] OPCODE_OP        = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
  localparam logic [6:0] OPCODE_OP_32     = 7'b0111011;
  localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_EXEC_LUI  = 4'd4,
    S_ALU_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_LOAD_ACC  = 4'd7,
    S_LOAD_WB   = 4'd8,
    S_STORE_ACC = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_JALR      = 4'd12
  } state_t;

  localparam logic [2:0] M2R_ALU_OUT  = 3'b000;
  localparam logic [2:0] M2R_MEM_DATA = 3'b001;
  localparam logic [2:0] M2R_PC       = 3'b010;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  localparam logic [1:0] SRC_A_RS1    = 2'b00;
  localparam logic [1:0] SRC_A_PC     = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] PC_SRC_ALU_RESULT = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT    = 2'b01;
  localparam logic [1:0] PC_SRC_JALR       = 2'b10;

  typedef struct packed {
    logic       pc_write_en;
    logic       branch_en;
    logic       ir_write_en;
    logic       inst_or_data;
    logic       mem_read_en;
    logic       mem_write_en;
    logic       regfile_write_en;
    logic [2:0] mem_to_reg_sel;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a_sel;
    logic [1:0] alu_src_b_sel;
    logic [1:0] pc_src_sel;
    logic       illegal_inst;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic is_load(input logic [6:0] opcode);
    return opcode == OPCODE_LOAD;
  endfunction

endpackage

// File: rtl/control_multicycle_opcode_class_decoder.sv
// Maps the IR opcode to the state that follows DECODE and flags opcodes
// the core does not implement.
module opcode_class_decoder
  import control_multicycle_pkg::*;
#(
  parameter bit SYSTEM_AS_NOP = 1'b0
) (
  input  logic [6:0] opcode,
  output state_t     next_state,
  output logic       illegal
);

  // Fence and SYSTEM simply retire by going back to FETCH.
  always_comb begin
    next_state = S_FETCH;
    illegal    = 1'b0;
    case (opcode)
      OPCODE_OP, OPCODE_OP_32:         next_state = S_EXEC_R;
      OPCODE_OP_IMM, OPCODE_OP_IMM_32: next_state = S_EXEC_I;
      OPCODE_LOAD, OPCODE_STORE:       next_state = S_MEM_ADDR;
      OPCODE_BRANCH:                   next_state = S_BRANCH;
      OPCODE_JAL:                      next_state = S_JAL;
      OPCODE_JALR:                     next_state = S_JALR;
      OPCODE_LUI:                      next_state = S_EXEC_LUI;
      OPCODE_AUIPC:                    next_state = S_ALU_WB;
      OPCODE_MISC_MEM:                 next_state = S_FETCH;
      OPCODE_SYSTEM:                   illegal = !SYSTEM_AS_NOP;
      default:                         illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_multicycle.sv
// Main control FSM of the RV64I multicycle core: sequences the shared ALU,
// the unified memory port and the register file across several cycles.
module control_multicycle
  import control_multicycle_pkg::*;
#(
  parameter bit SYSTEM_AS_NOP = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic       mem_ready,
  output logic       pc_write_en,
  output logic       branch_en,
  output logic       ir_write_en,
  output logic       inst_or_data,
  output logic       mem_read_en,
  output logic       mem_write_en,
  output logic       regfile_write_en,
  output logic [2:0] mem_to_reg_sel,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a_sel,
  output logic [1:0] alu_src_b_sel,
  output logic [1:0] pc_src_sel,
  output logic       illegal_inst,
  output logic [3:0] state_dbg
);

  state_t state;
  state_t decode_next;
  logic   decode_illegal;
  ctrl_t  ctrl;

  opcode_class_decoder #(
    .SYSTEM_AS_NOP(SYSTEM_AS_NOP)
  ) u_opcode_class_decoder (
    .opcode    (inst_opcode),
    .next_state(decode_next),
    .illegal   (decode_illegal)
  );

  // Single-cycle states and any unreachable encoding all fall back to FETCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:     if (mem_ready) state <= S_DECODE;
        S_DECODE:    state <= decode_next;
        S_EXEC_R:    state <= S_ALU_WB;
        S_EXEC_I:    state <= S_ALU_WB;
        S_EXEC_LUI:  state <= S_ALU_WB;
        S_MEM_ADDR:  state <= is_load(inst_opcode) ? S_LOAD_ACC : S_STORE_ACC;
        S_LOAD_ACC:  if (mem_ready) state <= S_LOAD_WB;
        S_STORE_ACC: if (mem_ready) state <= S_FETCH;
        default:     state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; only the FETCH-cycle IR/PC latch waits on mem_ready.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read_en   = 1'b1;
          ctrl.inst_or_data  = 1'b0;
          ctrl.alu_src_a_sel = SRC_A_PC;
          ctrl.alu_src_b_sel = SRC_B_FOUR;
          ctrl.alu_op        = ALU_OP_ADD;
          ctrl.pc_src_sel    = PC_SRC_ALU_RESULT;
          ctrl.ir_write_en   = mem_ready;
          ctrl.pc_write_en   = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_a_sel = SRC_A_OLD_PC;
          ctrl.alu_src_b_sel = SRC_B_IMM;
          ctrl.alu_op        = ALU_OP_ADD;
          ctrl.illegal_inst  = decode_illegal;
        end
        S_EXEC_R: begin
          ctrl.alu_src_a_sel = SRC_A_RS1;
          ctrl.alu_src_b_sel = SRC_B_RS2;
          ctrl.alu_op        = ALU_OP_RTYPE;
        end
        S_EXEC_I: begin
          ctrl.alu_src_a_sel = SRC_A_RS1;
          ctrl.alu_src_b_sel = SRC_B_IMM;
          ctrl.alu_op        = ALU_OP_ITYPE;
        end
        S_EXEC_LUI: begin
          ctrl.alu_src_a_sel = SRC_A_ZERO;
          ctrl.alu_src_b_sel = SRC_B_IMM;
          ctrl.alu_op        = ALU_OP_ADD;
        end
        S_ALU_WB: begin
          ctrl.regfile_write_en = 1'b1;
          ctrl.mem_to_reg_sel   = M2R_ALU_OUT;
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a_sel = SRC_A_RS1;
          ctrl.alu_src_b_sel = SRC_B_IMM;
          ctrl.alu_op        = ALU_OP_ADD;
        end
        S_LOAD_ACC: begin
          ctrl.mem_read_en  = 1'b1;
          ctrl.inst_or_data = 1'b1;
        end
        S_LOAD_WB: begin
          ctrl.regfile_write_en = 1'b1;
          ctrl.mem_to_reg_sel   = M2R_MEM_DATA;
        end
        S_STORE_ACC: begin
          ctrl.mem_write_en = 1'b1;
          ctrl.inst_or_data = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a_sel = SRC_A_RS1;
          ctrl.alu_src_b_sel = SRC_B_RS2;
          ctrl.alu_op        = ALU_OP_BRANCH;
          ctrl.branch_en     = 1'b1;
          ctrl.pc_src_sel    = PC_SRC_ALU_OUT;
        end
        // The register file sees the PC before this edge, i.e. old_pc+4.
        S_JAL: begin
          ctrl.pc_write_en      = 1'b1;
          ctrl.pc_src_sel       = PC_SRC_ALU_OUT;
          ctrl.regfile_write_en = 1'b1;
          ctrl.mem_to_reg_sel   = M2R_PC;
        end
        S_JALR: begin
          ctrl.alu_src_a_sel    = SRC_A_RS1;
          ctrl.alu_src_b_sel    = SRC_B_IMM;
          ctrl.alu_op           = ALU_OP_ADD;
          ctrl.pc_write_en      = 1'b1;
          ctrl.pc_src_sel       = PC_SRC_JALR;
          ctrl.regfile_write_en = 1'b1;
          ctrl.mem_to_reg_sel   = M2R_PC;
        end
        default: ctrl = CTRL_IDLE;
      endcase
    end
  end

  assign pc_write_en      = ctrl.pc_write_en;
  assign branch_en        = ctrl.branch_en;
  assign ir_write_en      = ctrl.ir_write_en;
  assign inst_or_data     = ctrl.inst_or_data;
  assign mem_read_en      = ctrl.mem_read_en;
  assign mem_write_en     = ctrl.mem_write_en;
  assign regfile_write_en = ctrl.regfile_write_en;
  assign mem_to_reg_sel   = ctrl.mem_to_reg_sel;
  assign alu_op           = ctrl.alu_op;
  assign alu_src_a_sel    = ctrl.alu_src_a_sel;
  assign alu_src_b_sel    = ctrl.alu_src_b_sel;
  assign pc_src_sel       = ctrl.pc_src_sel;
  assign illegal_inst     = ctrl.illegal_inst;
  assign state_dbg        = reset ? 4'd0 : 4'(state);

endmodule

// File: tb/tb_control_multicycle.sv
// Self-checking bench for control_multicycle: latency table, per-cycle
// reference model with random instructions, and reset corner cases.
module tb_control_multicycle;
  import control_multicycle_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] inst_opcode = 7'd0;
  logic       mem_ready = 1'b0;

  logic pc_write_en, branch_en, ir_write_en, inst_or_data, mem_read_en;
  logic mem_write_en, regfile_write_en, illegal_inst;
  logic [2:0] mem_to_reg_sel;
  logic [1:0] alu_op, alu_src_a_sel, alu_src_b_sel, pc_src_sel;
  logic [3:0] state_dbg;

  logic n_pc_write_en, n_branch_en, n_ir_write_en, n_inst_or_data, n_mem_read_en;
  logic n_mem_write_en, n_regfile_write_en, n_illegal_inst;
  logic [2:0] n_mem_to_reg_sel;
  logic [1:0] n_alu_op, n_alu_src_a_sel, n_alu_src_b_sel, n_pc_src_sel;
  logic [3:0] n_state_dbg;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  control_multicycle dut (
    .clock(clock), .reset(reset), .inst_opcode(inst_opcode), .mem_ready(mem_ready),
    .pc_write_en(pc_write_en), .branch_en(branch_en), .ir_write_en(ir_write_en),
    .inst_or_data(inst_or_data), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .regfile_write_en(regfile_write_en), .mem_to_reg_sel(mem_to_reg_sel), .alu_op(alu_op),
    .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel), .pc_src_sel(pc_src_sel),
    .illegal_inst(illegal_inst), .state_dbg(state_dbg)
  );

  control_multicycle #(.SYSTEM_AS_NOP(1'b1)) dut_nop (
    .clock(clock), .reset(reset), .inst_opcode(inst_opcode), .mem_ready(mem_ready),
    .pc_write_en(n_pc_write_en), .branch_en(n_branch_en), .ir_write_en(n_ir_write_en),
    .inst_or_data(n_inst_or_data), .mem_read_en(n_mem_read_en), .mem_write_en(n_mem_write_en),
    .regfile_write_en(n_regfile_write_en), .mem_to_reg_sel(n_mem_to_reg_sel), .alu_op(n_alu_op),
    .alu_src_a_sel(n_alu_src_a_sel), .alu_src_b_sel(n_alu_src_b_sel), .pc_src_sel(n_pc_src_sel),
    .illegal_inst(n_illegal_inst), .state_dbg(n_state_dbg)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, br, irw, iod, mrd, mwr, rfw;
    logic [2:0] m2r;
    logic [1:0] aop, sa, sb, ps;
    logic       ill;
  } obs_t;

  obs_t obs_main, obs_nop;
  assign obs_main = {state_dbg, pc_write_en, branch_en, ir_write_en, inst_or_data, mem_read_en,
                     mem_write_en, regfile_write_en, mem_to_reg_sel, alu_op, alu_src_a_sel,
                     alu_src_b_sel, pc_src_sel, illegal_inst};
  assign obs_nop  = {n_state_dbg, n_pc_write_en, n_branch_en, n_ir_write_en, n_inst_or_data,
                     n_mem_read_en, n_mem_write_en, n_regfile_write_en, n_mem_to_reg_sel, n_alu_op,
                     n_alu_src_a_sel, n_alu_src_b_sel, n_pc_src_sel, n_illegal_inst};

  typedef enum int {C_R, C_I, C_LUI, C_AUIPC, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR,
                    C_FENCE, C_SYS, C_BAD} cls_t;

  typedef struct {
    string      name;
    logic [6:0] opcode;
    int         fwait;
    int         mwait;
    int         cycles;
    int         ill_main;
    int         ill_nop;
  } vec_t;

  function automatic logic rnd_bit();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic cls_t classify(input logic [6:0] opc);
    case (opc)
      OPCODE_OP, OPCODE_OP_32:         return C_R;
      OPCODE_OP_IMM, OPCODE_OP_IMM_32: return C_I;
      OPCODE_LUI:                      return C_LUI;
      OPCODE_AUIPC:                    return C_AUIPC;
      OPCODE_LOAD:                     return C_LOAD;
      OPCODE_STORE:                    return C_STORE;
      OPCODE_BRANCH:                   return C_BR;
      OPCODE_JAL:                      return C_JAL;
      OPCODE_JALR:                     return C_JALR;
      OPCODE_MISC_MEM:                 return C_FENCE;
      OPCODE_SYSTEM:                   return C_SYS;
      default:                         return C_BAD;
    endcase
  endfunction

  // Expected outputs for one cycle spent in a given phase of an instruction.
  function automatic obs_t exp_of(input logic [3:0] st, input logic rdy, input logic ill);
    obs_t e = '0;
    e.st = st;
    case (st)
      S_FETCH:     begin e.mrd = 1; e.sa = 2'b01; e.sb = 2'b10; e.irw = rdy; e.pcw = rdy; end
      S_DECODE:    begin e.sa = 2'b10; e.sb = 2'b01; e.ill = ill; end
      S_EXEC_R:    begin e.aop = 2'b10; end
      S_EXEC_I:    begin e.sb = 2'b01; e.aop = 2'b11; end
      S_EXEC_LUI:  begin e.sa = 2'b11; e.sb = 2'b01; end
      S_ALU_WB:    begin e.rfw = 1; e.m2r = 3'b000; end
      S_MEM_ADDR:  begin e.sb = 2'b01; end
      S_LOAD_ACC:  begin e.mrd = 1; e.iod = 1; end
      S_LOAD_WB:   begin e.rfw = 1; e.m2r = 3'b001; end
      S_STORE_ACC: begin e.mwr = 1; e.iod = 1; end
      S_BRANCH:    begin e.aop = 2'b01; e.br = 1; e.ps = 2'b01; end
      S_JAL:       begin e.pcw = 1; e.ps = 2'b01; e.rfw = 1; e.m2r = 3'b010; end
      S_JALR:      begin e.sb = 2'b01; e.pcw = 1; e.ps = 2'b10; e.rfw = 1; e.m2r = 3'b010; end
      default:     e = '0;
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input logic rdy, input logic [6:0] opc, input logic rst);
    @(posedge clock);
    #1;
    mem_ready   = rdy;
    inst_opcode = opc;
    reset       = rst;
  endtask

  task automatic checkOutput(input string name, input obs_t em, input obs_t en);
    @(negedge clock);
    checks++;
    if (obs_main !== em) begin
      fails++;
      $display("[TB] FAIL %s (nop=0): got %h want %h", name, obs_main, em);
    end
    checks++;
    if (obs_nop !== en) begin
      fails++;
      $display("[TB] FAIL %s (nop=1): got %h want %h", name, obs_nop, en);
    end
  endtask

  task automatic step(input string name, input logic [3:0] st, input logic rdy,
                      input logic [6:0] opc, input logic rst, input logic ill_m, input logic ill_n);
    obs_t em, en;
    applyStimulus(rdy, opc, rst);
    em = rst ? obs_t'('0) : exp_of(st, rdy, ill_m);
    en = rst ? obs_t'('0) : exp_of(st, rdy, ill_n);
    checkOutput(name, em, en);
  endtask

  // Builds the phase sequence of one instruction from its class and wait counts.
  task automatic run_instr(input string name, input logic [6:0] opc, input int fwait, input int mwait);
    cls_t       c = classify(opc);
    logic [3:0] q[$];
    logic       rq[$];
    logic       ill_m = (c == C_BAD) || (c == C_SYS);
    logic       ill_n = (c == C_BAD);
    for (int i = 0; i < fwait; i++) begin q.push_back(S_FETCH); rq.push_back(1'b0); end
    q.push_back(S_FETCH);  rq.push_back(1'b1);
    q.push_back(S_DECODE); rq.push_back(rnd_bit());
    case (c)
      C_R:     begin q.push_back(S_EXEC_R);   q.push_back(S_ALU_WB); rq.push_back(rnd_bit()); rq.push_back(rnd_bit()); end
      C_I:     begin q.push_back(S_EXEC_I);   q.push_back(S_ALU_WB); rq.push_back(rnd_bit()); rq.push_back(rnd_bit()); end
      C_LUI:   begin q.push_back(S_EXEC_LUI); q.push_back(S_ALU_WB); rq.push_back(rnd_bit()); rq.push_back(rnd_bit()); end
      C_AUIPC: begin q.push_back(S_ALU_WB);  rq.push_back(rnd_bit()); end
      C_BR:    begin q.push_back(S_BRANCH);  rq.push_back(rnd_bit()); end
      C_JAL:   begin q.push_back(S_JAL);     rq.push_back(rnd_bit()); end
      C_JALR:  begin q.push_back(S_JALR);    rq.push_back(rnd_bit()); end
      C_LOAD, C_STORE: begin
        q.push_back(S_MEM_ADDR); rq.push_back(rnd_bit());
        for (int i = 0; i < mwait; i++) begin
          q.push_back(c == C_LOAD ? S_LOAD_ACC : S_STORE_ACC); rq.push_back(1'b0);
        end
        q.push_back(c == C_LOAD ? S_LOAD_ACC : S_STORE_ACC); rq.push_back(1'b1);
        if (c == C_LOAD) begin q.push_back(S_LOAD_WB); rq.push_back(rnd_bit()); end
      end
      default: ;
    endcase
    for (int i = 0; i < q.size(); i++) begin
      step($sformatf("%s_c%0d", name, i), q[i], rq[i],
           (q[i] == S_FETCH) ? 7'($urandom) : opc, 1'b0,
           (q[i] == S_DECODE) && ill_m, (q[i] == S_DECODE) && ill_n);
    end
  endtask

  // Latency measured by following state_dbg and answering memory requests.
  task automatic measure(input vec_t v);
    int cycles = 0, fcnt = 0, mcnt = 0, ill_m = 0, ill_n = 0;
    bit left = 0, done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clock);
      #1;
      reset = 1'b0;
      inst_opcode = v.opcode;
      if (state_dbg == S_FETCH && left) begin
        mem_ready = 1'b0;
        done = 1;
      end else begin
        if (state_dbg != S_FETCH) left = 1;
        cycles++;
        if (state_dbg == S_FETCH) begin
          mem_ready = (fcnt == v.fwait); fcnt++;
        end else if (state_dbg == S_LOAD_ACC || state_dbg == S_STORE_ACC) begin
          mem_ready = (mcnt == v.mwait); mcnt++;
        end else begin
          mem_ready = rnd_bit();
        end
        @(negedge clock);
        if (illegal_inst) ill_m++;
        if (n_illegal_inst) ill_n++;
      end
    end
    checks++;
    if (!done) begin
      fails++;
      $display("[TB] FAIL %s timeout: no return to FETCH after 40 cycles", v.name);
    end else if (cycles != v.cycles) begin
      fails++;
      $display("[TB] FAIL %s latency: got %0d cycles want %0d", v.name, cycles, v.cycles);
    end
    checks++;
    if (ill_m != v.ill_main) begin
      fails++;
      $display("[TB] FAIL %s illegal pulses (nop=0): got %0d want %0d", v.name, ill_m, v.ill_main);
    end
    checks++;
    if (ill_n != v.ill_nop) begin
      fails++;
      $display("[TB] FAIL %s illegal pulses (nop=1): got %0d want %0d", v.name, ill_n, v.ill_nop);
    end
  endtask

  initial begin
    vec_t       table_v[$];
    logic [6:0] legal[13];

    table_v.push_back('{"add",   OPCODE_OP,        0, 0, 4, 0, 0});
    table_v.push_back('{"addi",  OPCODE_OP_IMM,    0, 0, 4, 0, 0});
    table_v.push_back('{"addw",  OPCODE_OP_32,     1, 0, 5, 0, 0});
    table_v.push_back('{"addiw", OPCODE_OP_IMM_32, 0, 0, 4, 0, 0});
    table_v.push_back('{"lui",   OPCODE_LUI,       0, 0, 4, 0, 0});
    table_v.push_back('{"auipc", OPCODE_AUIPC,     0, 0, 3, 0, 0});
    table_v.push_back('{"lw0",   OPCODE_LOAD,      0, 0, 5, 0, 0});
    table_v.push_back('{"lw2",   OPCODE_LOAD,      0, 2, 7, 0, 0});
    table_v.push_back('{"sw",    OPCODE_STORE,     1, 1, 6, 0, 0});
    table_v.push_back('{"beq",   OPCODE_BRANCH,    0, 0, 3, 0, 0});
    table_v.push_back('{"jal",   OPCODE_JAL,       0, 0, 3, 0, 0});
    table_v.push_back('{"jalr",  OPCODE_JALR,      2, 0, 5, 0, 0});
    table_v.push_back('{"fence", OPCODE_MISC_MEM,  0, 0, 2, 0, 0});
    table_v.push_back('{"ecall", OPCODE_SYSTEM,    0, 0, 2, 1, 0});
    table_v.push_back('{"bad",   7'b1111111,       0, 0, 2, 1, 1});

    legal = '{OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM, OPCODE_AUIPC, OPCODE_OP_IMM_32,
              OPCODE_STORE, OPCODE_OP, OPCODE_LUI, OPCODE_OP_32, OPCODE_BRANCH, OPCODE_JALR,
              OPCODE_JAL, OPCODE_SYSTEM};

    // Reset held two cycles with mem_ready high, then the first instruction.
    step("reset0", S_FETCH, 1'b1, 7'($urandom), 1'b1, 1'b0, 1'b0);
    step("reset1", S_FETCH, 1'b1, 7'($urandom), 1'b1, 1'b0, 1'b0);
    run_instr("add", OPCODE_OP, 0, 0);
    run_instr("lw_wait2", OPCODE_LOAD, 0, 2);
    run_instr("jal", OPCODE_JAL, 0, 0);
    run_instr("illegal", 7'b1111111, 0, 0);
    run_instr("system", OPCODE_SYSTEM, 1, 0);

    for (int i = 0; i < table_v.size(); i++) measure(table_v[i]);

    for (int i = 0; i < 40; i++) begin
      logic [6:0] opc = ($urandom_range(0, 3) == 0) ? 7'($urandom) : legal[$urandom_range(0, 12)];
      run_instr($sformatf("rnd%0d", i), opc, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Store interrupted by reset in its second wait cycle, mem_ready high.
    step("sw_fetch",  S_FETCH,     1'b1, OPCODE_STORE, 1'b0, 1'b0, 1'b0);
    step("sw_decode", S_DECODE,    1'b1, OPCODE_STORE, 1'b0, 1'b0, 1'b0);
    step("sw_addr",   S_MEM_ADDR,  1'b1, OPCODE_STORE, 1'b0, 1'b0, 1'b0);
    step("sw_wait1",  S_STORE_ACC, 1'b0, OPCODE_STORE, 1'b0, 1'b0, 1'b0);
    step("sw_reset",  S_FETCH,     1'b1, OPCODE_STORE, 1'b1, 1'b0, 1'b0);
    step("sw_after",  S_FETCH,     1'b0, OPCODE_STORE, 1'b0, 1'b0, 1'b0);
    step("sw_hold",   S_FETCH,     1'b0, OPCODE_STORE, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/control_multicycle.md
Name: control_multicycle

Overview:
Main control FSM for the RV64I multicycle core. It sequences one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction. Selects are driven from the current state and the IR opcode, and memory accesses stall on a ready handshake. It sits beside the multicycle datapath and takes the place of the single-cycle combinational control unit.

Parameters:
SYSTEM_AS_NOP, 0, 1: SYSTEM opcode (1110011) retires as a no-op; 0: it raises illegal_inst.

Ports:
clock  input  1  core clock; all state changes on rising edge
reset  input  1  synchronous, active-high
inst_opcode  input  7  IR[6:0]; valid from DECODE onward
mem_ready  input  1  memory completes the current access this cycle
pc_write_en  output  1  unconditional PC write
branch_en  output  1  PC write qualified by the datapath branch comparator
ir_write_en  output  1  latch IR and old_pc
inst_or_data  output  1  memory address source: 0 = PC, 1 = alu_out
mem_read_en  output  1  memory read request
mem_write_en  output  1  memory write request
regfile_write_en  output  1  register file write
mem_to_reg_sel  output  3  000 alu_out, 001 mem_data, 010 PC register (= old_pc+4)
alu_op  output  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct (word variants come from opcode bit 3 in the ALU control)
alu_src_a_sel  output  2  00 rs1, 01 PC, 10 old_pc, 11 zero
alu_src_b_sel  output  2  00 rs2, 01 imm, 10 constant 4
pc_src_sel  output  2  00 alu_result, 01 alu_out, 10 alu_result & ~1
illegal_inst  output  1  one-cycle pulse on an unsupported opcode
state_dbg  output  4  current state encoding

Behaviour:
- Moore outputs decoded from state. Exception: ir_write_en and pc_write_en in FETCH are ANDed with mem_ready. Any output not listed for a state is 0.
- Reset: while reset=1, all outputs are 0 and the state is forced to FETCH on the edge. This also applies mid-instruction, mid-wait, or with mem_ready high in the same cycle. The first FETCH output is on the cycle after reset deasserts.
- FETCH: mem_read_en=1, inst_or_data=0, a=01, b=10, alu_op=00, pc_src=00. Holds while mem_ready=0. When mem_ready=1: ir_write_en=1, pc_write_en=1, then go to DECODE.
- DECODE: a=10, b=01, add, so alu_out = old_pc+imm (branch/JAL/AUIPC target). Next state by opcode:
  - OP / OP-32 -> EXEC_R
  - OP-IMM / OP-IMM-32 -> EXEC_I
  - LOAD / STORE -> MEM_ADDR
  - BRANCH -> BRANCH
  - JAL -> JAL
  - JALR -> JALR
  - LUI -> EXEC_LUI
  - AUIPC -> ALU_WB
  - MISC-MEM (fence) -> FETCH
  - SYSTEM -> FETCH, with illegal_inst=1 unless SYSTEM_AS_NOP
  - any other opcode -> FETCH with illegal_inst=1 (asserted in DECODE)
- EXEC_R: a=00, b=00, alu_op=10 -> ALU_WB.
- EXEC_I: a=00, b=01, alu_op=11 -> ALU_WB.
- EXEC_LUI: a=11, b=01, add -> ALU_WB.
- ALU_WB: regfile_write_en=1, mem_to_reg=000 -> FETCH.
- MEM_ADDR: a=00, b=01, add -> LOAD_ACC if LOAD, else STORE_ACC.
- LOAD_ACC: mem_read_en=1, inst_or_data=1. Holds until mem_ready, then -> LOAD_WB.
- LOAD_WB: regfile_write_en=1, mem_to_reg=001 -> FETCH.
- STORE_ACC: mem_write_en=1, inst_or_data=1. Holds until mem_ready, then -> FETCH. mem_write_en stays high for the whole wait.
- BRANCH: a=00, b=00, alu_op=01, branch_en=1, pc_src=01 -> FETCH.
- JAL: pc_write_en=1, pc_src=01, regfile_write_en=1, mem_to_reg=010 -> FETCH. The register file captures the pre-edge PC.
- JALR: a=00, b=01, add, pc_write_en=1, pc_src=10, regfile_write_en=1, mem_to_reg=010 -> FETCH.
- Instruction latency with zero wait states (mem_ready always 1):
  - 3 cycles: branch, JAL, JALR, AUIPC
  - 4 cycles: R, I, LUI, store
  - 5 cycles: load
  - Each memory wait cycle adds 1.
- mem_ready outside FETCH, LOAD_ACC and STORE_ACC is ignored.
- An unreachable state encoding returns to FETCH on the next edge with all outputs 0.

Decomposition:
- Shared include file: opcode constants (OPCODE_LOAD ... OPCODE_SYSTEM), the state encodings, and the select encodings for mem_to_reg_sel, alu_src_*, pc_src_sel and alu_op. The same file is reused by the datapath and the bench.
- One sub-module, opcode_class_decoder: combinational inst_opcode -> next state out of DECODE, plus an illegal flag, with SYSTEM_AS_NOP passed through.

Test Plan:
- Reset held 2 cycles with mem_ready=1, then released: outputs all 0 during reset. Next cycle state_dbg=FETCH, mem_read_en=1, ir_write_en=1.
- add (0110011), mem_ready=1: FETCH, DECODE, EXEC_R (alu_op=10), ALU_WB (regfile_write_en=1, mem_to_reg=000), then FETCH. 4 cycles total.
- lw (0000011) with mem_ready low for 2 cycles in LOAD_ACC: LOAD_ACC lasts 3 cycles with inst_or_data=1. LOAD_WB has mem_to_reg=001. Total 7 cycles.
- jal (1101111): DECODE has a=10, b=01. The JAL state has pc_write_en=1, pc_src=01, regfile_write_en=1, mem_to_reg=010. 3 cycles.
- Opcode 1111111: illegal_inst=1 for exactly the DECODE cycle, then FETCH. Opcode 1110011 with SYSTEM_AS_NOP=1 gives no pulse.
- sw with reset asserted in the second STORE_ACC wait cycle: mem_write_en drops to 0 that cycle, and the state is FETCH after the edge.
